// File: rtl/updn_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : updn_sweep_ctrl_if
// Brief   : Host and counter-side signal bundle for updn_sweep_ctrl.
// Revision: 1.0
// ============================================================================
interface updn_sweep_ctrl_if;
    logic        start;
    logic [15:0] lo_lim;
    logic [15:0] hi_lim;
    logic [7:0]  num_sweeps;
    logic        hold;
    logic [15:0] cnt_val;
    logic        ld_cnt;
    logic        updn_cnt;
    logic        count_enb;
    logic [15:0] cnt_load_val;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  sweep_cnt;
`ifdef SWEEP_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    modport master (
        output start, lo_lim, hi_lim, num_sweeps, hold, cnt_val,
        input  ld_cnt, updn_cnt, count_enb, cnt_load_val,
        input  busy, done, err, sweep_cnt
`ifdef SWEEP_ABORT_EN
        , output abort
        , input  aborted
`endif
    );

    modport slave (
        input  start, lo_lim, hi_lim, num_sweeps, hold, cnt_val,
        output ld_cnt, updn_cnt, count_enb, cnt_load_val,
        output busy, done, err, sweep_cnt
`ifdef SWEEP_ABORT_EN
        , input  abort
        , output aborted
`endif
    );
endinterface
`default_nettype wire

// File: rtl/updn_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : updn_sweep_ctrl
// Brief   : Triangle-sweep sequencer for a 16-bit up/down counter.
//           Optional abort input/pulse enabled by macro SWEEP_ABORT_EN.
// Revision: 1.0
// ============================================================================
module updn_sweep_ctrl (
    input  logic              clk,
    input  logic              rst_,
    updn_sweep_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_lo;
    logic [15:0] r_hi;
    logic [7:0]  r_num;
    logic [7:0]  r_sweep;
    logic        r_done;
    logic        r_err;
    logic        w_ld_cnt;
    logic        w_updn;
    logic        w_enb;
    logic        w_accept;
    logic        w_err;
    logic        w_sweep_inc;
    logic        w_in_range;
    logic [8:0]  w_sweep_next;
`ifdef SWEEP_ABORT_EN
    logic        r_aborted;
    logic        w_abort;
`endif

    assign w_in_range   = (bus.cnt_val >= r_lo) && (bus.cnt_val <= r_hi);
    assign w_sweep_next = {1'b0, r_sweep} + 9'd1;

    always_comb begin
        w_next      = r_state;
        w_ld_cnt    = 1'b1;
        w_updn      = 1'b1;
        w_enb       = 1'b0;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        w_sweep_inc = 1'b0;
`ifdef SWEEP_ABORT_EN
        w_abort     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if ((bus.lo_lim < bus.hi_lim) && (bus.num_sweeps != 8'd0)) begin
                        w_accept = 1'b1;
                        w_next   = S_LOAD;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_ld_cnt = 1'b0;
                w_next   = S_UP;
            end
            S_UP: begin
                w_enb = 1'b1;
                if (bus.hold) begin
                    w_enb = 1'b0;
                end else if (!w_in_range) begin
                    w_enb  = 1'b0;
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (bus.cnt_val == r_hi) begin
                    // Reverse in the same cycle so the counter never passes hi.
                    w_updn = 1'b0;
                    w_next = S_DOWN;
                end
            end
            S_DOWN: begin
                w_enb  = 1'b1;
                w_updn = 1'b0;
                if (bus.hold) begin
                    w_enb = 1'b0;
                end else if (!w_in_range) begin
                    w_enb  = 1'b0;
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (bus.cnt_val == r_lo) begin
                    w_sweep_inc = 1'b1;
                    if (w_sweep_next < {1'b0, r_num}) begin
                        w_updn = 1'b1;
                        w_next = S_UP;
                    end else begin
                        w_enb  = 1'b0;
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
`ifdef SWEEP_ABORT_EN
        // Abort overrides hold, turnarounds and range errors.
        if (bus.abort && ((r_state == S_LOAD) || (r_state == S_UP) || (r_state == S_DOWN))) begin
            w_enb       = 1'b0;
            w_ld_cnt    = 1'b1;
            w_err       = 1'b0;
            w_sweep_inc = 1'b0;
            w_abort     = 1'b1;
            w_next      = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state <= S_IDLE;
            r_lo    <= 16'd0;
            r_hi    <= 16'd0;
            r_num   <= 8'd0;
            r_sweep <= 8'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == S_DONE);
            r_err   <= w_err;
            if (w_accept) begin
                r_lo    <= bus.lo_lim;
                r_hi    <= bus.hi_lim;
                r_num   <= bus.num_sweeps;
                r_sweep <= 8'd0;
            end else if (w_sweep_inc) begin
                r_sweep <= r_sweep + 8'd1;
            end
        end
    end

`ifdef SWEEP_ABORT_EN
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort;
        end
    end

    assign bus.aborted = r_aborted;
`endif

    assign bus.ld_cnt       = w_ld_cnt;
    assign bus.updn_cnt     = w_updn;
    assign bus.count_enb    = w_enb;
    assign bus.cnt_load_val = r_lo;
    assign bus.busy         = (r_state == S_LOAD) || (r_state == S_UP) || (r_state == S_DOWN);
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.sweep_cnt    = r_sweep;
endmodule
`default_nettype wire

// File: tb/tb_updn_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_updn_sweep_ctrl
// Brief   : Directed self-checking bench for updn_sweep_ctrl with a counter model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_updn_sweep_ctrl;
    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    updn_sweep_ctrl_if bus();
    updn_sweep_ctrl dut (.clk(clk), .rst_(rst_), .bus(bus));

    // Behavioural model of the external up/down counter.
    logic [15:0] r_cnt     = 16'd0;
    logic        force_en  = 1'b0;
    logic [15:0] force_val = 16'd0;
    always @(posedge clk) begin
        if (!bus.ld_cnt)
            r_cnt <= bus.cnt_load_val;
        else if (bus.count_enb)
            r_cnt <= bus.updn_cnt ? r_cnt + 16'd1 : r_cnt - 16'd1;
    end
    assign bus.cnt_val = force_en ? force_val : r_cnt;

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] basic_seq [5] = '{16'd2, 16'd3, 16'd4, 16'd3, 16'd2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Returns at the negedge after the start edge, i.e. in the LOAD cycle.
    task automatic start_run(input logic [15:0] lo, input logic [15:0] hi, input logic [7:0] n);
        bus.lo_lim     = lo;
        bus.hi_lim     = hi;
        bus.num_sweeps = n;
        bus.start      = 1'b1;
        step();
        bus.start      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.lo_lim = 16'd0; bus.hi_lim = 16'd0;
        bus.num_sweeps = 8'd0; bus.hold = 1'b0;
`ifdef SWEEP_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (3) step();
        chk("rst_ld", bus.ld_cnt, 1);
        chk("rst_updn", bus.updn_cnt, 1);
        chk("rst_enb", bus.count_enb, 0);
        chk("rst_loadval", bus.cnt_load_val, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_sweep", bus.sweep_cnt, 0);
`ifdef SWEEP_ABORT_EN
        chk("rst_aborted", bus.aborted, 0);
`endif
        rst_ = 1'b1;
        step();

        // Basic single sweep lo=2 hi=4
        start_run(16'd2, 16'd4, 8'd1);
        chk("load_ld", bus.ld_cnt, 0);
        chk("load_val", bus.cnt_load_val, 2);
        chk("load_busy", bus.busy, 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("basic_cnt", bus.cnt_val, basic_seq[i-1]);
            chk("basic_nodone", bus.done, 0);
            if (i == 3) chk("basic_turn_updn", bus.updn_cnt, 0);
            if (i == 5) chk("basic_end_enb", bus.count_enb, 0);
        end
        step();
        chk("basic_done", bus.done, 1);
        chk("basic_busy", bus.busy, 0);
        chk("basic_sweep", bus.sweep_cnt, 1);
        step();
        chk("basic_done_pulse", bus.done, 0);
        chk("basic_idle_ld", bus.ld_cnt, 1);

        // Two sweeps lo=0 hi=3 with a 3-cycle hold at the peak
        start_run(16'd0, 16'd3, 8'd2);
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i >= 4 && i <= 7) chk("hold_peak_cnt", bus.cnt_val, 3);
            if (i == 5) chk("hold_enb", bus.count_enb, 0);
            if (i == 8) chk("hold_after_cnt", bus.cnt_val, 2);
            if (i == 12) chk("hold_mid_sweep", bus.sweep_cnt, 1);
            if (i < 17) chk("hold_nodone", bus.done, 0);
            if (i == 4) bus.hold = 1'b1;
            if (i == 7) bus.hold = 1'b0;
        end
        chk("hold_done", bus.done, 1);
        chk("hold_sweep", bus.sweep_cnt, 2);
        step();

        // Rejected starts: equal limits, then zero sweeps
        start_run(16'd5, 16'd5, 8'd1);
        chk("inv_eq_err", bus.err, 1);
        chk("inv_eq_busy", bus.busy, 0);
        chk("inv_eq_ld", bus.ld_cnt, 1);
        chk("inv_keep_sweep", bus.sweep_cnt, 2);
        step();
        chk("inv_eq_err_pulse", bus.err, 0);
        chk("inv_eq_ld2", bus.ld_cnt, 1);
        start_run(16'd1, 16'd5, 8'd0);
        chk("inv_n0_err", bus.err, 1);
        chk("inv_n0_ld", bus.ld_cnt, 1);
        step();
        chk("inv_n0_busy", bus.busy, 0);
        chk("inv_n0_ld2", bus.ld_cnt, 1);

        // Start during a run is ignored
        start_run(16'd2, 16'd4, 8'd1);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 2) begin
                bus.lo_lim = 16'd0; bus.hi_lim = 16'd9; bus.num_sweeps = 8'd3;
                bus.start = 1'b1;
            end
            if (i == 3) begin
                chk("busy_start_cnt", bus.cnt_val, 4);
                bus.start = 1'b0;
            end
        end
        chk("busy_start_done", bus.done, 1);
        chk("busy_start_sweep", bus.sweep_cnt, 1);
        step();

        // Off-range counter value during UP
        start_run(16'd0, 16'h000A, 8'd1);
        step();
        step();
        chk("off_pre_cnt", bus.cnt_val, 1);
        force_en = 1'b1;
        force_val = 16'h0010;
        #1;
        chk("off_mealy_enb", bus.count_enb, 0);
        step();
        chk("off_err", bus.err, 1);
        chk("off_busy", bus.busy, 0);
        chk("off_enb", bus.count_enb, 0);
        chk("off_ld", bus.ld_cnt, 1);
        force_en = 1'b0;
        step();
        chk("off_err_pulse", bus.err, 0);

        // Reset in the middle of the second sweep
        start_run(16'd0, 16'd2, 8'd2);
        repeat (7) step();
        chk("mrst_pre_sweep", bus.sweep_cnt, 1);
        chk("mrst_pre_busy", bus.busy, 1);
        rst_ = 1'b0;
        step();
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_ld", bus.ld_cnt, 1);
        chk("mrst_enb", bus.count_enb, 0);
        chk("mrst_sweep", bus.sweep_cnt, 0);
        rst_ = 1'b1;
        step();

`ifdef SWEEP_ABORT_EN
        // Abort while holding in DOWN
        start_run(16'd0, 16'd3, 8'd1);
        repeat (5) step();
        chk("abt_pre_cnt", bus.cnt_val, 2);
        bus.hold  = 1'b1;
        bus.abort = 1'b1;
        #1;
        chk("abt_enb", bus.count_enb, 0);
        chk("abt_ld", bus.ld_cnt, 1);
        step();
        chk("abt_pulse", bus.aborted, 1);
        chk("abt_busy", bus.busy, 0);
        chk("abt_nodone", bus.done, 0);
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        step();
        chk("abt_pulse_end", bus.aborted, 0);
        chk("abt_nodone2", bus.done, 0);
        chk("abt_idle", bus.busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
